// File: rtl/zl_bus_if.sv
// Requester handshake and serial-link signals shared by zl_bus_master and its environment.
interface zl_bus_if;
  logic [1:0] req;
  logic [1:0] we;
  logic [6:0] addr0;
  logic [6:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] rdata;
  logic       err;
  logic       busy;
  logic       tx_o;
  logic       rx_i;

  modport master (
    input  req, we, addr0, addr1, wdata0, wdata1, rx_i,
    output gnt, done, rdata, err, busy, tx_o
  );

  modport slave (
    output req, we, addr0, addr1, wdata0, wdata1, rx_i,
    input  gnt, done, rdata, err, busy, tx_o
  );
endinterface

// File: rtl/zl_bus_master.sv
// Round-robin two-requester sequencer for the bit-per-clock serial register link:
// sends address (and write-data) frames, captures read frames with a start-bit timeout.
module zl_bus_master #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic     clk,
  input  logic     reset,
  zl_bus_if.master bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TMO_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_GAP   = 3'd2,
    S_WDATA = 3'd3,
    S_RWAIT = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_rx_s1;
  logic                r_rx_s2;
  logic                r_rr;
  logic                r_owner;
  logic                r_we;
  logic [DATA_W-1:0]   r_abyte;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]    r_gap_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic                r_err;
  logic                r_busy;
  logic                r_tx;
  logic                w_win;

  // On a tie the requester that was not served last wins.
  assign w_win = (bus.req == 2'b11) ? ~r_rr : bus.req[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rr      <= 1'b1;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_abyte   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_tmo_cnt <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rx_i;
      r_rx_s2 <= r_rx_s1;
      r_gnt   <= '0;
      r_done  <= '0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (bus.req != 2'b00) begin
            r_rr      <= w_win;
            r_owner   <= w_win;
            r_we      <= bus.we[w_win];
            r_abyte   <= {(w_win ? bus.addr1 : bus.addr0), bus.we[w_win]};
            r_wdata   <= w_win ? bus.wdata1 : bus.wdata0;
            r_gnt     <= {w_win, ~w_win};
            r_tx      <= 1'b0;
            r_bit_cnt <= CNT_W'(DATA_W);
            r_busy    <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        // The grant cycle carries the start bit; the counter then walks bits 7..0.
        S_ADDR: begin
          if (r_bit_cnt != '0) begin
            r_tx      <= r_abyte[3'(r_bit_cnt - 4'd1)];
            r_bit_cnt <= r_bit_cnt - 4'd1;
          end else begin
            r_tx <= 1'b1;
            if (r_we) begin
              r_gap_cnt <= CNT_W'(GAP_CYCLES - 1);
              r_state   <= S_GAP;
            end else begin
              r_tmo_cnt <= '0;
              r_state   <= S_RWAIT;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end else begin
            r_tx      <= 1'b0;
            r_bit_cnt <= CNT_W'(DATA_W);
            r_state   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (r_bit_cnt != '0) begin
            r_tx      <= r_wdata[3'(r_bit_cnt - 4'd1)];
            r_bit_cnt <= r_bit_cnt - 4'd1;
          end else begin
            r_tx    <= 1'b1;
            r_err   <= 1'b0;
            r_done  <= {r_owner, ~r_owner};
            r_state <= S_DONE;
          end
        end
        // A start bit seen on the last counted cycle still beats the timeout.
        S_RWAIT: begin
          if (!r_rx_s2) begin
            r_bit_cnt <= CNT_W'(DATA_W);
            r_state   <= S_RDATA;
          end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_rdata <= 8'hFF;
            r_done  <= {r_owner, ~r_owner};
            r_state <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        S_RDATA: begin
          r_rdata   <= {r_rdata[DATA_W-2:0], r_rx_s2};
          r_bit_cnt <= r_bit_cnt - 4'd1;
          if (r_bit_cnt == 4'd1) begin
            r_err   <= 1'b0;
            r_done  <= {r_owner, ~r_owner};
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;
  assign bus.tx_o  = r_tx;

endmodule
